// File: rtl/axis_strb_pkg.sv
// Shared definitions for the AXI-Stream strobe-aware width converters
// (64-to-32 splitter and its 32-to-64 packer neighbour).
//   - Canonical TSTRB patterns for whole, low-half, high-half and empty beats
//   - Half-word sequencer state encoding
//   - Helpers that classify one 4-bit strobe nibble
package axis_strb_pkg;

    localparam logic [7:0] STRB_FULL = 8'hff;
    localparam logic [7:0] STRB_LO   = 8'h0f;
    localparam logic [7:0] STRB_HI   = 8'hf0;
    localparam logic [7:0] STRB_NONE = 8'h00;

    typedef enum logic {
        ST_LO = 1'b0,
        ST_HI = 1'b1
    } half_st_e;

    // Any set strobe bit makes the 32-bit half worth sending.
    function automatic logic half_valid(input logic [3:0] nib);
        return |nib;
    endfunction

    // Partial nibbles are still sent but flag a protocol violation.
    function automatic logic nib_bad(input logic [3:0] nib);
        return (nib != 4'h0) && (nib != 4'hf);
    endfunction

endpackage

// File: rtl/axis_64to32_strb.sv
// 64-bit to 32-bit AXI-Stream width-down converter driven by TSTRB.
// Each accepted 64-bit beat is held in a single register and emitted as
// up to two 32-bit words (low half first); halves whose strobe nibble is
// zero are skipped, so a 0x0f beat yields one word and a 0x00 beat none.
//
// Ports:
//   AXIS_ACLK, AXIS_ARESETN      clock, synchronous active-low reset
//   S_AXIS_T{VALID,READY,DATA,STRB,LAST,USER}   64-bit input stream
//   M_AXIS_T{VALID,READY,DATA,LAST,USER}        32-bit output stream
//   STRB_ERR                     one-cycle pulse on a strobe violation
module axis_64to32_strb
    import axis_strb_pkg::*;
#(
    parameter int USER_WIDTH = 32
) (
    input  logic                  AXIS_ACLK,
    input  logic                  AXIS_ARESETN,
    input  logic                  S_AXIS_TVALID,
    output logic                  S_AXIS_TREADY,
    input  logic [63:0]           S_AXIS_TDATA,
    input  logic [7:0]            S_AXIS_TSTRB,
    input  logic                  S_AXIS_TLAST,
    input  logic [USER_WIDTH-1:0] S_AXIS_TUSER,
    output logic                  M_AXIS_TVALID,
    input  logic                  M_AXIS_TREADY,
    output logic [31:0]           M_AXIS_TDATA,
    output logic                  M_AXIS_TLAST,
    output logic [USER_WIDTH-1:0] M_AXIS_TUSER,
    output logic                  STRB_ERR
);

    logic [63:0]           data_q, data_d;
    logic [7:0]            strb_q, strb_d;
    logic                  last_q, last_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  full_q, full_d;
    half_st_e              state_q, state_d;
    logic                  err_q, err_d;

    logic hi_v_q;
    logic s_lo_v, s_hi_v, s_bad;
    logic m_xfr, final_xfr, s_xfr;

    assign hi_v_q = half_valid(strb_q[7:4]);

    assign s_lo_v = half_valid(S_AXIS_TSTRB[3:0]);
    assign s_hi_v = half_valid(S_AXIS_TSTRB[7:4]);
    assign s_bad  = nib_bad(S_AXIS_TSTRB[3:0]) || nib_bad(S_AXIS_TSTRB[7:4]) ||
                    ((S_AXIS_TSTRB == STRB_NONE) && S_AXIS_TLAST);

    // final_xfr: the word leaving now is the last valid half of the held
    // beat, so the register frees up this cycle and can take a new beat.
    assign m_xfr     = full_q && M_AXIS_TREADY;
    assign final_xfr = m_xfr && ((state_q == ST_HI) || !hi_v_q);

    assign S_AXIS_TREADY = AXIS_ARESETN && (!full_q || final_xfr);
    assign s_xfr         = S_AXIS_TVALID && S_AXIS_TREADY;

    // Outputs come straight from held state, never from M_AXIS_TREADY.
    assign M_AXIS_TVALID = full_q;
    assign M_AXIS_TDATA  = (state_q == ST_HI) ? data_q[63:32] : data_q[31:0];
    assign M_AXIS_TLAST  = (state_q == ST_HI) ? last_q : (last_q && !hi_v_q);
    assign M_AXIS_TUSER  = user_q;
    assign STRB_ERR      = err_q;

    always_comb begin
        data_d  = data_q;
        strb_d  = strb_q;
        last_d  = last_q;
        user_d  = user_q;
        full_d  = full_q;
        state_d = state_q;
        err_d   = s_xfr && s_bad;

        if (m_xfr) begin
            if ((state_q == ST_LO) && hi_v_q) begin
                state_d = ST_HI;
            end else begin
                full_d  = 1'b0;
                state_d = ST_LO;
            end
        end

        // A new beat overrides the consume above. An all-zero beat is
        // swallowed: the register is left (or becomes) empty.
        if (s_xfr && (s_lo_v || s_hi_v)) begin
            data_d  = S_AXIS_TDATA;
            strb_d  = S_AXIS_TSTRB;
            last_d  = S_AXIS_TLAST;
            user_d  = S_AXIS_TUSER;
            full_d  = 1'b1;
            state_d = s_lo_v ? ST_LO : ST_HI;
        end
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (!AXIS_ARESETN) begin
            data_q  <= '0;
            strb_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            full_q  <= 1'b0;
            state_q <= ST_LO;
            err_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            strb_q  <= strb_d;
            last_q  <= last_d;
            user_q  <= user_d;
            full_q  <= full_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_axis_64to32_strb.sv
module tb_axis_64to32_strb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, s_last;
    logic [63:0] s_data;
    logic [7:0]  s_strb;
    logic [31:0] s_user;
    logic        m_valid, m_ready, m_last;
    logic [31:0] m_data, m_user;
    logic        strb_err;

    always #5 clk = ~clk;

    axis_64to32_strb #(.USER_WIDTH(32)) dut (
        .AXIS_ACLK     (clk),
        .AXIS_ARESETN  (rst_n),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TSTRB  (s_strb),
        .S_AXIS_TLAST  (s_last),
        .S_AXIS_TUSER  (s_user),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TUSER  (m_user),
        .STRB_ERR      (strb_err)
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [31:0] user;
    } word_t;

    word_t exp_q[$];
    int    n_chk = 0, n_pass = 0;
    int    n_err = 0, exp_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // Scoreboard: expected words pushed on input handshake, popped on output.
    initial begin
        logic        prev_stall = 1'b0;
        logic [31:0] prev_data  = '0;
        logic        prev_last  = 1'b0;
        logic [31:0] prev_user  = '0;
        word_t       e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_stall = 1'b0;
            end else begin
                if (strb_err) n_err++;
                if (prev_stall) begin
                    chk("hold_vld",  64'(m_valid), 64'(1));
                    chk("hold_data", 64'(m_data),  64'(prev_data));
                    chk("hold_last", 64'(m_last),  64'(prev_last));
                    chk("hold_user", 64'(m_user),  64'(prev_user));
                end
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("extra_word", 64'(m_data), 64'hdead_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk("tdata", 64'(m_data), 64'(e.data));
                        chk("tlast", 64'(m_last), 64'(e.last));
                        chk("tuser", 64'(m_user), 64'(e.user));
                    end
                end
                if (s_valid && s_ready) begin
                    if (|s_strb[3:0])
                        exp_q.push_back('{s_data[31:0], s_last && !(|s_strb[7:4]), s_user});
                    if (|s_strb[7:4])
                        exp_q.push_back('{s_data[63:32], s_last, s_user});
                    if ((s_strb[3:0] != 4'h0 && s_strb[3:0] != 4'hf) ||
                        (s_strb[7:4] != 4'h0 && s_strb[7:4] != 4'hf) ||
                        (s_strb == 8'h00 && s_last))
                        exp_err++;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
                prev_user  = m_user;
            end
        end
    end

    // Called at #1 after a posedge; returns at #1 after the accepting edge.
    task automatic send_beat(input logic [63:0] d, input logic [7:0] s,
                             input logic l, input logic [31:0] u);
        int n = 0;
        s_valid = 1'b1; s_data = d; s_strb = s; s_last = l; s_user = u;
        @(negedge clk);
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) chk("accept_timeout", 64'(0), 64'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (4) @(posedge clk);
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        int e0;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_strb = '0;
        s_last = 1'b0; s_user = '0; m_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_sready", 64'(s_ready),  64'(0));
        chk("rst_mvalid", 64'(m_valid),  64'(0));
        chk("rst_tdata",  64'(m_data),   64'(0));
        chk("rst_tlast",  64'(m_last),   64'(0));
        chk("rst_tuser",  64'(m_user),   64'(0));
        chk("rst_err",    64'(strb_err), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        m_ready = 1'b1;

        // Full beat followed by trailing half beat
        send_beat(64'h1111_2222_3333_4444, 8'hff, 1'b0, 32'h0000_00a1);
        send_beat(64'h5555_6666_7777_8888, 8'h0f, 1'b1, 32'h0000_00a2);
        drain();

        // High-half-only beat
        send_beat(64'hAAAA_BBBB_CCCC_DDDD, 8'hf0, 1'b1, 32'h0000_00b1);
        drain();

        // Backpressure 1-0-0-1 across a full beat, next beat waiting
        s_valid = 1'b1; s_data = 64'hC0C1_C2C3_C4C5_C6C7; s_strb = 8'hff;
        s_last = 1'b0; s_user = 32'h0000_00c1; m_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_a", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        s_data = 64'hD0D1_D2D3_D4D5_D6D7; s_strb = 8'hff; s_last = 1'b1;
        s_user = 32'h0000_00d1;
        @(negedge clk);
        chk("bp_first_vld", 64'(m_valid), 64'(1));
        chk("bp_sready_lo", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        m_ready = 1'b0;
        @(negedge clk);
        chk("bp_sready_st1", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_sready_st2", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        m_ready = 1'b1;
        @(negedge clk);
        chk("bp_sready_hi", 64'(s_ready), 64'(1));
        @(posedge clk); #1;
        s_valid = 1'b0;
        drain();

        // Zero-strobe beat with TLAST: no word, one error pulse
        e0 = n_err;
        send_beat(64'h0123_4567_89ab_cdef, 8'h00, 1'b1, 32'h0000_00e1);
        drain();
        chk("err_zero", 64'(n_err - e0), 64'(1));

        // Partial strobe nibble: both halves, one error pulse
        e0 = n_err;
        send_beat(64'hF0F1_F2F3_F4F5_F6F7, 8'h3f, 1'b1, 32'h0000_00f1);
        drain();
        chk("err_partial", 64'(n_err - e0), 64'(1));

        // Reset after the low half of a full beat has transferred
        send_beat(64'h0102_0304_0506_0708, 8'hff, 1'b0, 32'h0000_0011);
        @(negedge clk);
        chk("mr_lo_vld", 64'(m_valid), 64'(1));
        @(posedge clk); #1;
        rst_n = 1'b0; m_ready = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mr_sready", 64'(s_ready), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("mr_mvalid", 64'(m_valid), 64'(0));
        chk("mr_tdata",  64'(m_data),  64'(0));
        chk("mr_tuser",  64'(m_user),  64'(0));
        @(posedge clk); #1;
        m_ready = 1'b1;
        send_beat(64'h9999_8888_7777_6666, 8'h0f, 1'b1, 32'h0000_0022);
        drain();

        chk("err_total", 64'(n_err), 64'(exp_err));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
